sense_sequencer: RTL and testbench

SENSE_SEQUENCER -- requirements
Module: sense_sequencer

---
 rtl/sense_sequencer.sv | 145 ++++++++++++++
 tb/tb_sense_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sense_sequencer.sv
// Sense measurement sequencer: IDLE -> BIAS -> LED -> CLEAR, with the comparator resynchronised before sampling.
// Define SENSE_SEQUENCER_MAJORITY_EN for 2-of-3 majority sampling over the last three LED cycles.
module sense_sequencer #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             continuous,
  input  logic [CNT_W-1:0] settle_cyc,
  input  logic [CNT_W-1:0] led_cyc,
  input  logic             cmp_in,
  output logic             bias_en,
  output logic             led_en,
  output logic             sample_stb,
  output logic             latch_clr,
  output logic             result,
  output logic             result_valid,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BIAS  = 2'd1;
  localparam logic [1:0] ST_LED   = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

`ifdef SENSE_SEQUENCER_MAJORITY_EN
  localparam logic [CNT_W-1:0] LED_MIN  = CNT_W'(3);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(2);
`else
  localparam logic [CNT_W-1:0] LED_MIN  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(0);
`endif

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   smp;
  logic                   decision;

  // Clamp a duration to its minimum and convert it to a count-down preload (count reaches 0 on the last cycle).
  function automatic logic [CNT_W-1:0] dur_load(input logic [CNT_W-1:0] cyc,
                                                input logic [CNT_W-1:0] min_cyc);
    logic [CNT_W-1:0] eff;
    eff = (cyc < min_cyc) ? min_cyc : cyc;
    return eff - CNT_W'(1);
  endfunction

  // Stage: comparator resynchronisation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p[0] <= cmp_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign smp = sync_p[SYNC_STAGES-1];

`ifdef SENSE_SEQUENCER_MAJORITY_EN
  logic [1:0] maj_p;

  // Stage: hold the two earlier strobed samples until the third arrives
  always_ff @(posedge clk) begin
    if (!rst_n) maj_p <= '0;
    else if (sample_stb) maj_p <= {maj_p[0], smp};
  end

  assign decision = (maj_p[1] & maj_p[0]) | (maj_p[1] & smp) | (maj_p[0] & smp);
`else
  assign decision = smp;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ena && start) begin
          state_d = ST_BIAS;
          cnt_d   = dur_load(settle_cyc, CNT_W'(1));
        end
      end
      ST_BIAS: begin
        if (!ena) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_LED;
          cnt_d   = dur_load(led_cyc, LED_MIN);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LED: begin
        if (!ena) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_CLEAR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
        if (ena && continuous) begin
          state_d = ST_BIAS;
          cnt_d   = dur_load(settle_cyc, CNT_W'(1));
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Stage: state, counter and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bias_en      <= 1'b0;
      led_en       <= 1'b0;
      sample_stb   <= 1'b0;
      latch_clr    <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bias_en      <= (state_d == ST_BIAS) || (state_d == ST_LED);
      led_en       <= (state_d == ST_LED);
      sample_stb   <= (state_d == ST_LED) && (cnt_d <= STB_LAST);
      latch_clr    <= (state_d == ST_CLEAR);
      result_valid <= (state_d == ST_CLEAR);
      busy         <= (state_d != ST_IDLE);
      if ((state_q == ST_LED) && (state_d == ST_CLEAR)) result <= decision;
    end
  end

endmodule

// File: tb/tb_sense_sequencer.sv
// Randomised bench for sense_sequencer; expected outputs come from a timeline model that paints phase windows per cycle.
module tb_sense_sequencer;

  localparam int CNT_W = 8;
  localparam int SS    = 2;
  localparam int N     = 5000;
  localparam int NA    = N + 700;
`ifdef SENSE_SEQUENCER_MAJORITY_EN
  localparam int LMIN = 3;
`else
  localparam int LMIN = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n, ena, start, continuous, cmp_in;
  logic [CNT_W-1:0] settle_cyc, led_cyc;
  logic             bias_en, led_en, sample_stb, latch_clr, result, result_valid, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bias_end = -1;

  bit exp_bias [NA];
  bit exp_led  [NA];
  bit exp_stb  [NA];
  bit exp_clr  [NA];
  bit exp_busy [NA];
  bit exp_res  [NA];
  bit cmp_hist [NA];
  bit rst_hist [NA];

  sense_sequencer #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .continuous(continuous),
    .settle_cyc(settle_cyc), .led_cyc(led_cyc), .cmp_in(cmp_in),
    .bias_en(bias_en), .led_en(led_en), .sample_stb(sample_stb), .latch_clr(latch_clr),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  // Comparator value seen after the synchroniser during cycle x; any reset within the last SS cycles flushes it.
  function automatic bit smp_at(input int x);
    if (x - SS < 0) return 1'b0;
    for (int k = 1; k <= SS; k++) if (rst_hist[x-k]) return 1'b0;
    return cmp_hist[x-SS];
  endfunction

  function automatic bit decide(input int last_led);
`ifdef SENSE_SEQUENCER_MAJORITY_EN
    int ones;
    ones = int'(smp_at(last_led-2)) + int'(smp_at(last_led-1)) + int'(smp_at(last_led));
    return ones >= 2;
`else
    return smp_at(last_led);
`endif
  endfunction

  task automatic erase(input int from);
    for (int i = from; i < from + 600 && i < NA; i++) begin
      exp_bias[i] = 0; exp_led[i] = 0; exp_stb[i] = 0; exp_clr[i] = 0; exp_busy[i] = 0;
    end
    bias_end = -1;
  endtask

  function automatic logic [CNT_W-1:0] pick_dur();
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) return CNT_W'(255);
    if (r < 6) return CNT_W'($urandom_range(5, 20));
    return CNT_W'($urandom_range(0, 4));
  endfunction

  // Decide what the edge ending cycle c does to the expected timeline.
  task automatic model_step(input int c);
    int c1, s, l;
    c1 = c + 1;
    exp_res[c1] = exp_res[c];
    if (!rst_n) begin
      erase(c1);
      exp_res[c1] = 1'b0;
    end else if (exp_busy[c] && !ena) begin
      erase(c1);
    end else begin
      if (exp_clr[c1]) exp_res[c1] = decide(c);
      if (bias_end == c) begin
        l = (int'(led_cyc) < LMIN) ? LMIN : int'(led_cyc);
        for (int i = 1; i <= l; i++) begin
          exp_bias[c+i] = 1; exp_led[c+i] = 1; exp_busy[c+i] = 1;
          exp_stb[c+i]  = (i > l - LMIN);
        end
        exp_clr[c+l+1]  = 1;
        exp_busy[c+l+1] = 1;
        bias_end = -1;
      end
      if ((!exp_busy[c] && ena && start) || (exp_clr[c] && ena && continuous)) begin
        s = (settle_cyc == '0) ? 1 : int'(settle_cyc);
        for (int i = 1; i <= s; i++) begin
          exp_bias[c+i] = 1; exp_busy[c+i] = 1;
        end
        bias_end = c + s;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; continuous = 1'b0; cmp_in = 1'b0;
    settle_cyc = '0; led_cyc = '0;
    for (int c = 0; c < N; c++) begin
      cyc = c;
      if (c > 0) begin
        @(negedge clk);
        check("bias_en",      bias_en,      exp_bias[c]);
        check("led_en",       led_en,       exp_led[c]);
        check("sample_stb",   sample_stb,   exp_stb[c]);
        check("latch_clr",    latch_clr,    exp_clr[c]);
        check("result_valid", result_valid, exp_clr[c]);
        check("busy",         busy,         exp_busy[c]);
        check("result",       result,       exp_res[c]);
      end
      rst_n  = (c < 3) ? 1'b0 : ($urandom_range(0, 399) != 0);
      ena    = ($urandom_range(0, 199) != 0);
      start  = ($urandom_range(0, 3) == 0);
      cmp_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) continuous = ~continuous;
      if ($urandom_range(0, 9) == 0) settle_cyc = pick_dur();
      if ($urandom_range(0, 9) == 0) led_cyc = pick_dur();
      cmp_hist[c] = cmp_in;
      rst_hist[c] = !rst_n;
      model_step(c);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
